// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern engine: FILL / CHASE / DRAIN (and BOUNCE when LED_BOUNCE_EN is defined).
// Latency: a restart loads step 0 one clki after reset release or a {mode,dir} change; steps every DIV_CNT enabled cycles.
// Backpressure: none; en=0 freezes divider, step and led. Without LED_BOUNCE_EN, mode 11 runs as CHASE.
module led_pattern_gen #(
  parameter int N_LED   = 8,
  parameter int DIV_CNT = 50_000_000
) (
  input  logic             clki,
  input  logic             rs,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [N_LED-1:0] led,
  output logic             step_tick,
  output logic             done
);

  localparam int SW = $clog2(N_LED + 1);
  localparam int DW = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;

  localparam logic [SW-1:0] STEP_LAST_FD = SW'(N_LED);      // FILL/DRAIN last step
  localparam logic [SW-1:0] STEP_LAST_CH = SW'(N_LED - 1);  // CHASE/BOUNCE top position
  localparam logic [DW-1:0] DIV_LAST     = DW'(DIV_CNT - 1);

  logic [N_LED-1:0] r_led;
  logic             r_tick;
  logic             r_done;
  logic [DW-1:0]    r_div;
  logic [SW-1:0]    r_step;
  logic             r_pend;
  logic [1:0]       r_mode;
  logic             r_dir;
`ifdef LED_BOUNCE_EN
  logic             r_bdir;       // 0 = moving up, 1 = moving back down
  logic             w_next_bdir;
`endif

  logic             w_restart;
  logic [SW-1:0]    w_next_step;
  logic             w_wrap;
  logic [N_LED-1:0] w_led_step0;
  logic [N_LED-1:0] w_led_next;

  // Pattern for a given mode/direction/step; dir=1 mirrors the dir=0 pattern.
  function automatic logic [N_LED-1:0] f_pattern(input logic [1:0]    m,
                                                 input logic          d,
                                                 input logic [SW-1:0] s);
    logic [N_LED-1:0] v;
    logic [N_LED-1:0] r;
    v = '0;
    r = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (m)
        2'b00:   v[i] = (i <  int'(s));   // FILL: low s bits set
        2'b10:   v[i] = (i >= int'(s));   // DRAIN: low s bits cleared
        default: v[i] = (i == int'(s));   // CHASE / BOUNCE: single lit LED
      endcase
    end
    for (int i = 0; i < N_LED; i++) begin
      r[N_LED-1-i] = v[i];
    end
    return d ? r : v;
  endfunction

  assign w_restart   = r_pend || (mode != r_mode) || (dir != r_dir);
  assign w_led_step0 = f_pattern(mode, dir, '0);
  assign w_led_next  = f_pattern(r_mode, r_dir, w_next_step);

  // Next step position and wrap flag for the currently registered mode.
  always_comb begin
    w_next_step = r_step + SW'(1);
    w_wrap      = 1'b0;
`ifdef LED_BOUNCE_EN
    w_next_bdir = r_bdir;
`endif
    case (r_mode)
      2'b00, 2'b10: begin
        if (r_step == STEP_LAST_FD) begin
          w_next_step = '0;
          w_wrap      = 1'b1;
        end
      end
`ifdef LED_BOUNCE_EN
      2'b11: begin
        if (!r_bdir && (r_step != STEP_LAST_CH)) begin
          w_next_step = r_step + SW'(1);
        end else begin
          // Heading down (or turning at the top); arrival at 0 is the wrap.
          w_next_step = r_step - SW'(1);
          if (r_step == SW'(1)) begin
            w_wrap      = 1'b1;
            w_next_bdir = 1'b0;
          end else begin
            w_next_bdir = 1'b1;
          end
        end
      end
`endif
      default: begin
        if (r_step == STEP_LAST_CH) begin
          w_next_step = '0;
          w_wrap      = 1'b1;
        end
      end
    endcase
  end

  // Restart / divider / step sequencing; restart outranks en and a coincident step.
  always_ff @(posedge clki or posedge rs) begin
    if (rs) begin
      r_led  <= '0;
      r_tick <= 1'b0;
      r_done <= 1'b0;
      r_div  <= '0;
      r_step <= '0;
      r_pend <= 1'b1;
      r_mode <= 2'b00;
      r_dir  <= 1'b0;
`ifdef LED_BOUNCE_EN
      r_bdir <= 1'b0;
`endif
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      if (w_restart) begin
        r_pend <= 1'b0;
        r_mode <= mode;
        r_dir  <= dir;
        r_div  <= '0;
        r_step <= '0;
        r_led  <= w_led_step0;
`ifdef LED_BOUNCE_EN
        r_bdir <= 1'b0;
`endif
      end else if (en) begin
        if (r_div == DIV_LAST) begin
          r_div  <= '0;
          r_tick <= 1'b1;
          r_done <= w_wrap;
          r_step <= w_next_step;
          r_led  <= w_led_next;
`ifdef LED_BOUNCE_EN
          r_bdir <= w_next_bdir;
`endif
        end else begin
          r_div <= r_div + DW'(1);
        end
      end
    end
  end

  assign led       = r_led;
  assign step_tick = r_tick;
  assign done      = r_done;

endmodule
